// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM/DIP download loader.
package rom_loader_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StHalf,
      StWrite,
      StFlush
   } state_e;

   localparam int unsigned DIP_BANK_SIZE     = 8;
   localparam logic [7:0]  DEFAULT_ROM_INDEX = 8'd0;
   localparam logic [7:0]  DEFAULT_DIP_INDEX = 8'd254;

endpackage

// File: rtl/rom_loader_dip_bank.sv
// DIP-switch bank: 8x8 register file with byte-addressed write, no reset.
module dip_bank
   import rom_loader_pkg::*;
(
   input  logic                         clk,
   input  logic                         we,
   input  logic [2:0]                   addr,
   input  logic [7:0]                   din,
   output logic [8*DIP_BANK_SIZE-1:0]   dsw_flat
);

   // Stored complemented so that the all-zero power-up state reads back as 8'hFF.
   logic [7:0] inv_q [DIP_BANK_SIZE];

   // Byte write; deliberately no reset so an OSD reset keeps the switches.
   always_ff @(posedge clk) begin
      if (we) begin
         inv_q[addr] <= ~din;
      end
   end

   // Flatten the bank, undoing the storage inversion.
   always_comb begin
      for (int i = 0; i < DIP_BANK_SIZE; i++) begin
         dsw_flat[8*i +: 8] = ~inv_q[i];
      end
   end

endmodule

// File: rtl/rom_loader.sv
// Packs hps_io download bytes into 16-bit SDRAM writes and loads the DIP bank.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter logic [7:0] ROM_INDEX = DEFAULT_ROM_INDEX,
   parameter logic [7:0] DIP_INDEX = DEFAULT_DIP_INDEX
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_be,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic [63:0] dsw_flat,
   output logic        load_done,
   output logic [23:0] word_count
);

   state_e      state_q, state_d;
   logic [7:0]  lo_q, lo_d;
   logic [23:0] hold_addr_q, hold_addr_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_din_q, mem_din_d;
   logic [1:0]  mem_be_q, mem_be_d;
   logic        stage_valid_q, stage_valid_d;
   logic [24:0] stage_addr_q, stage_addr_d;
   logic [7:0]  stage_data_q, stage_data_d;
   logic [23:0] word_count_q, word_count_d;
   logic        load_done_q, load_done_d;
   logic        rom_dl_q, rom_dl_d;
   logic        dl_q;

   logic        rom_strobe;
   logic        dip_we;
   logic        src_valid;
   logic [24:0] src_addr;
   logic [7:0]  src_data;

   // Strobes seen while ioctl_wait is high are dropped outright.
   assign rom_strobe = ioctl_wr && !ioctl_wait && ioctl_download && (ioctl_index == ROM_INDEX);
   assign dip_we     = ioctl_wr && !ioctl_wait && (ioctl_index == DIP_INDEX) &&
                       (ioctl_addr[24:3] == 22'd0);

   assign ioctl_wait = (state_q == StWrite) || (state_q == StFlush) || stage_valid_q;
   assign mem_we     = (state_q == StWrite);
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;
   assign mem_be     = mem_be_q;
   assign load_done  = load_done_q;
   assign word_count = word_count_q;

   // Pick the byte that starts a new word: a live strobe in IDLE, or the staged byte on ack.
   always_comb begin
      src_valid = 1'b0;
      src_addr  = ioctl_addr;
      src_data  = ioctl_dout;
      if (state_q == StIdle) begin
         src_valid = rom_strobe;
      end else if ((state_q == StWrite) && mem_ack && stage_valid_q) begin
         src_valid = 1'b1;
         src_addr  = stage_addr_q;
         src_data  = stage_data_q;
      end
   end

   // Next-state and datapath decode.
   always_comb begin
      state_d       = state_q;
      lo_d          = lo_q;
      hold_addr_d   = hold_addr_q;
      mem_addr_d    = mem_addr_q;
      mem_din_d     = mem_din_q;
      mem_be_d      = mem_be_q;
      stage_valid_d = stage_valid_q;
      stage_addr_d  = stage_addr_q;
      stage_data_d  = stage_data_q;
      word_count_d  = word_count_q;
      rom_dl_d      = rom_dl_q;
      load_done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
         end
         StHalf: begin
            mem_addr_d = hold_addr_q;
            if (rom_strobe) begin
               if (ioctl_addr[0] && (ioctl_addr[24:1] == hold_addr_q)) begin
                  mem_din_d = {ioctl_dout, lo_q};
                  mem_be_d  = 2'b11;
               end else begin
                  // Park the new byte and flush the lone even byte first.
                  mem_din_d     = {8'h00, lo_q};
                  mem_be_d      = 2'b01;
                  stage_valid_d = 1'b1;
                  stage_addr_d  = ioctl_addr;
                  stage_data_d  = ioctl_dout;
               end
               state_d = StWrite;
            end else if (!ioctl_download) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            mem_addr_d = hold_addr_q;
            mem_din_d  = {8'h00, lo_q};
            mem_be_d   = 2'b01;
            state_d    = StWrite;
         end
         StWrite: begin
            if (mem_ack) begin
               word_count_d  = word_count_q + 24'd1;
               stage_valid_d = 1'b0;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (src_valid) begin
         if (!src_addr[0]) begin
            lo_d        = src_data;
            hold_addr_d = src_addr[24:1];
            state_d     = StHalf;
         end else begin
            mem_addr_d = src_addr[24:1];
            mem_din_d  = {src_data, 8'h00};
            mem_be_d   = 2'b10;
            state_d    = StWrite;
         end
      end

      if (rom_dl_q && !ioctl_download && (state_q == StIdle) && !stage_valid_q) begin
         load_done_d = 1'b1;
         rom_dl_d    = 1'b0;
      end
      if (ioctl_download && (ioctl_index == ROM_INDEX)) begin
         rom_dl_d = 1'b1;
      end
      if (ioctl_download && !dl_q) begin
         word_count_d = '0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q       <= StIdle;
         lo_q          <= '0;
         hold_addr_q   <= '0;
         mem_addr_q    <= '0;
         mem_din_q     <= '0;
         mem_be_q      <= '0;
         stage_valid_q <= 1'b0;
         stage_addr_q  <= '0;
         stage_data_q  <= '0;
         word_count_q  <= '0;
         load_done_q   <= 1'b0;
         rom_dl_q      <= 1'b0;
         dl_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         lo_q          <= lo_d;
         hold_addr_q   <= hold_addr_d;
         mem_addr_q    <= mem_addr_d;
         mem_din_q     <= mem_din_d;
         mem_be_q      <= mem_be_d;
         stage_valid_q <= stage_valid_d;
         stage_addr_q  <= stage_addr_d;
         stage_data_q  <= stage_data_d;
         word_count_q  <= word_count_d;
         load_done_q   <= load_done_d;
         rom_dl_q      <= rom_dl_d;
         dl_q          <= ioctl_download;
      end
   end

   dip_bank u_dip_bank (
      .clk      (clk_sys),
      .we       (dip_we),
      .addr     (ioctl_addr[2:0]),
      .din      (ioctl_dout),
      .dsw_flat (dsw_flat)
   );

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader with an SDRAM responder and a byte-pairing model.
module tb_rom_loader;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] din;
      logic [1:0]  be;
   } wr_t;

   typedef struct packed {
      logic [24:0] addr;
      logic [7:0]  data;
   } byte_t;

   logic        clk_sys        = 1'b0;
   logic        reset          = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr       = 1'b0;
   logic [7:0]  ioctl_index    = 8'd0;
   logic [24:0] ioctl_addr     = '0;
   logic [7:0]  ioctl_dout     = '0;
   logic        ioctl_wait;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_be;
   logic        mem_we;
   logic        mem_ack;
   logic [63:0] dsw_flat;
   logic        load_done;
   logic [23:0] word_count;

   int  checks    = 0;
   int  passed    = 0;
   int  ld_count  = 0;
   int  we_cycles = 0;
   int  viol      = 0;
   int  unstable  = 0;
   int  ack_lat   = -1;
   bit  resp_en   = 1'b1;
   bit  spur_en   = 1'b0;
   wr_t   rec_q[$];
   wr_t   exp_q[$];
   byte_t stim_q[$];
   logic [7:0] dip_m [8];

   rom_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_index    (ioctl_index),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_be         (mem_be),
      .mem_we         (mem_we),
      .mem_ack        (mem_ack),
      .dsw_flat       (dsw_flat),
      .load_done      (load_done),
      .word_count     (word_count)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   // Event monitors (outputs sampled on the falling edge).
   always @(negedge clk_sys) begin
      if (load_done) ld_count++;
      if (mem_we) we_cycles++;
      if (mem_we && !ioctl_wait) viol++;
   end

   // SDRAM controller model: acks after a latency, records enabled bytes only.
   initial begin : responder
      int  d;
      wr_t first;
      d       = -1;
      first   = '0;
      mem_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         mem_ack = 1'b0;
         if (!mem_we) begin
            d = -1;
            if (spur_en && ($urandom_range(0, 3) == 0)) mem_ack = 1'b1;
         end else begin
            if (d < 0) begin
               if (ack_lat < 0) d = int'($urandom_range(0, 3));
               else d = ack_lat;
               first = '{mem_addr, mem_din, mem_be};
            end
            if (mem_addr !== first.addr || mem_din !== first.din || mem_be !== first.be)
               unstable++;
            if (resp_en) begin
               if (d == 0) begin
                  rec_q.push_back('{mem_addr,
                                    mem_din & {{8{mem_be[1]}}, {8{mem_be[0]}}}, mem_be});
                  mem_ack = 1'b1;
                  d       = -1;
               end else begin
                  d--;
               end
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic do_reset();
      @(negedge clk_sys);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
   endtask

   task automatic start_dl(input logic [7:0] idx);
      @(negedge clk_sys);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      int k = 0;
      @(negedge clk_sys);
      while (ioctl_wait && k < 200) begin
         @(negedge clk_sys);
         k++;
      end
      if (ioctl_wait) begin
         checks++;
         $display("FAIL send_wait: ioctl_wait stuck at %b, required 0", ioctl_wait);
      end
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
   endtask

   task automatic end_dl(input int bound);
      int k  = 0;
      int b0 = ld_count;
      @(negedge clk_sys);
      ioctl_download = 1'b0;
      while (ld_count == b0 && k < bound) begin
         @(negedge clk_sys);
         k++;
      end
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic wait_rec(input int n, input int bound);
      int k = 0;
      while (rec_q.size() < n && k < bound) begin
         @(negedge clk_sys);
         k++;
      end
   endtask

   // Reference: pair an even byte with the immediately following odd byte of the same word.
   task automatic build_expected();
      bit          have;
      logic [23:0] ha;
      logic [7:0]  hb;
      logic [24:0] a;
      logic [7:0]  d;
      exp_q.delete();
      have = 1'b0;
      ha   = '0;
      hb   = '0;
      foreach (stim_q[i]) begin
         a = stim_q[i].addr;
         d = stim_q[i].data;
         if (have && a[0] && (a[24:1] == ha)) begin
            exp_q.push_back('{ha, {d, hb}, 2'b11});
            have = 1'b0;
         end else begin
            if (have) exp_q.push_back('{ha, {8'h00, hb}, 2'b01});
            have = 1'b0;
            if (a[0]) exp_q.push_back('{a[24:1], {d, 8'h00}, 2'b10});
            else begin
               have = 1'b1;
               ha   = a[24:1];
               hb   = d;
            end
         end
      end
      if (have) exp_q.push_back('{ha, {8'h00, hb}, 2'b01});
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we);
      else passed++;
      checks++; if (ioctl_wait !== 1'b0) $display("FAIL rst_wait: got %b want 0", ioctl_wait);
      else passed++;
      checks++; if (mem_be !== 2'b00) $display("FAIL rst_be: got %b want 00", mem_be);
      else passed++;
      checks++; if (mem_addr !== 24'd0) $display("FAIL rst_addr: got %h want 0", mem_addr);
      else passed++;
      checks++; if (mem_din !== 16'd0) $display("FAIL rst_din: got %h want 0", mem_din);
      else passed++;
      checks++; if (load_done !== 1'b0) $display("FAIL rst_done: got %b want 0", load_done);
      else passed++;
      checks++; if (word_count !== 24'd0) $display("FAIL rst_wc: got %0d want 0", word_count);
      else passed++;
      checks++;
      if (dsw_flat !== {8{8'hFF}}) $display("FAIL rst_dsw: got %h want all FF", dsw_flat);
      else passed++;
   endtask

   task automatic test_pair();
      int  base = rec_q.size();
      int  ldb  = ld_count;
      wr_t e;
      ack_lat = 2;
      start_dl(8'd0);
      send_byte(25'd0, 8'h11);
      send_byte(25'd1, 8'h22);
      checks++; if (mem_we !== 1'b1) $display("FAIL pair_we: got %b want 1", mem_we);
      else passed++;
      checks++; if (ioctl_wait !== 1'b1) $display("FAIL pair_wait: got %b want 1", ioctl_wait);
      else passed++;
      wait_rec(base + 1, 20);
      repeat (2) @(negedge clk_sys);
      checks++;
      if (word_count !== 24'd1) $display("FAIL pair_wc: got %0d want 1", word_count);
      else passed++;
      end_dl(100);
      e = '{24'd0, 16'h2211, 2'b11};
      checks++;
      if (rec_q.size() != base + 1) $display("FAIL pair_count: got %0d want 1", rec_q.size() - base);
      else if (rec_q[base] !== e)
         $display("FAIL pair_write: got %h/%h/%b want %h/%h/%b", rec_q[base].addr,
                  rec_q[base].din, rec_q[base].be, e.addr, e.din, e.be);
      else passed++;
      checks++;
      if (ld_count - ldb != 1) $display("FAIL pair_done: got %0d pulses want 1", ld_count - ldb);
      else passed++;
   endtask

   task automatic test_five();
      int         base = rec_q.size();
      int         ldb  = ld_count;
      logic [7:0] d [5];
      wr_t        e [3];
      ack_lat = -1;
      for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
      e[0] = '{24'd0, {d[1], d[0]}, 2'b11};
      e[1] = '{24'd1, {d[3], d[2]}, 2'b11};
      e[2] = '{24'd2, {8'h00, d[4]}, 2'b01};
      start_dl(8'd0);
      for (int i = 0; i < 5; i++) send_byte(25'(i), d[i]);
      end_dl(100);
      checks++;
      if (rec_q.size() != base + 3) $display("FAIL five_count: got %0d want 3", rec_q.size() - base);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (base + i >= rec_q.size()) $display("FAIL five_write[%0d]: got none want %h", i, e[i]);
         else if (rec_q[base+i] !== e[i])
            $display("FAIL five_write[%0d]: got %h want %h", i, rec_q[base+i], e[i]);
         else passed++;
      end
      checks++;
      if (word_count !== 24'd3) $display("FAIL five_wc: got %0d want 3", word_count);
      else passed++;
      checks++;
      if (ld_count - ldb != 1) $display("FAIL five_done: got %0d pulses want 1", ld_count - ldb);
      else passed++;
   endtask

   task automatic test_stage();
      int         base = rec_q.size();
      int         lows = 0;
      int         k    = 0;
      logic [7:0] b6   = 8'($urandom);
      logic [7:0] b10  = 8'($urandom);
      wr_t        e0, e1;
      ack_lat = 3;
      e0 = '{24'd3, {8'h00, b6}, 2'b01};
      e1 = '{24'd5, {8'h00, b10}, 2'b01};
      start_dl(8'd0);
      send_byte(25'd6, b6);
      send_byte(25'd10, b10);
      checks++;
      if (ioctl_wait !== 1'b1) $display("FAIL stage_wait0: got %b want 1", ioctl_wait);
      else passed++;
      while (rec_q.size() < base + 1 && k < 20) begin
         @(negedge clk_sys);
         if (!ioctl_wait) lows++;
         k++;
      end
      checks++;
      if (lows != 0) $display("FAIL stage_wait_hold: got %0d low cycles want 0", lows);
      else passed++;
      @(negedge clk_sys);
      checks++;
      if (mem_we !== 1'b0) $display("FAIL stage_half_we: got %b want 0", mem_we);
      else passed++;
      end_dl(100);
      checks++;
      if (rec_q.size() != base + 2) $display("FAIL stage_count: got %0d want 2", rec_q.size() - base);
      else if (rec_q[base] !== e0 || rec_q[base+1] !== e1)
         $display("FAIL stage_writes: got %h,%h want %h,%h", rec_q[base], rec_q[base+1], e0, e1);
      else passed++;
      checks++;
      if (word_count !== 24'd2) $display("FAIL stage_wc: got %0d want 2", word_count);
      else passed++;
   endtask

   task automatic test_dip();
      int          web = we_cycles;
      int          ldb = ld_count;
      logic [63:0] exp_dsw;
      logic [24:0] a;
      logic [7:0]  d;
      start_dl(8'd254);
      checks++;
      if (word_count !== 24'd0) $display("FAIL dl_rise_wc: got %0d want 0", word_count);
      else passed++;
      send_byte(25'd3, 8'hA5);
      dip_m[3] = 8'hA5;
      send_byte(25'd9, 8'h5A);
      @(negedge clk_sys);
      for (int i = 0; i < 8; i++) exp_dsw[8*i +: 8] = dip_m[i];
      checks++;
      if (dsw_flat !== exp_dsw) $display("FAIL dip_directed: got %h want %h", dsw_flat, exp_dsw);
      else passed++;
      for (int n = 0; n < 12; n++) begin
         a = 25'($urandom_range(0, 15));
         d = 8'($urandom);
         send_byte(a, d);
         if (a < 25'd8) dip_m[a[2:0]] = d;
      end
      @(negedge clk_sys);
      for (int i = 0; i < 8; i++) exp_dsw[8*i +: 8] = dip_m[i];
      checks++;
      if (dsw_flat !== exp_dsw) $display("FAIL dip_random: got %h want %h", dsw_flat, exp_dsw);
      else passed++;
      end_dl(5);
      checks++;
      if (we_cycles != web) $display("FAIL dip_no_mem: got %0d we cycles want 0", we_cycles - web);
      else passed++;
      checks++;
      if (ld_count != ldb) $display("FAIL dip_no_done: got %0d pulses want 0", ld_count - ldb);
      else passed++;
   endtask

   task automatic test_reset_mid_write();
      int          base = rec_q.size();
      int          k    = 0;
      logic [63:0] snap;
      wr_t         e;
      resp_en = 1'b0;
      start_dl(8'd0);
      send_byte(25'd1, 8'h3C);
      while (!mem_we && k < 20) begin
         @(negedge clk_sys);
         k++;
      end
      checks++;
      if (mem_we !== 1'b1) $display("FAIL rmw_pending: got %b want 1", mem_we);
      else passed++;
      snap = dsw_flat;
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      checks++; if (mem_we !== 1'b0) $display("FAIL rmw_we: got %b want 0", mem_we);
      else passed++;
      checks++; if (ioctl_wait !== 1'b0) $display("FAIL rmw_wait: got %b want 0", ioctl_wait);
      else passed++;
      checks++; if (mem_be !== 2'b00) $display("FAIL rmw_be: got %b want 00", mem_be);
      else passed++;
      checks++; if (dsw_flat !== snap) $display("FAIL rmw_dsw: got %h want %h", dsw_flat, snap);
      else passed++;
      resp_en = 1'b1;
      end_dl(100);
      start_dl(8'd0);
      send_byte(25'h20, 8'h05);
      send_byte(25'h21, 8'h06);
      end_dl(100);
      e = '{24'h10, 16'h0605, 2'b11};
      checks++;
      if (rec_q.size() != base + 1) $display("FAIL rmw_count: got %0d want 1", rec_q.size() - base);
      else if (rec_q[base] !== e) $display("FAIL rmw_after: got %h want %h", rec_q[base], e);
      else passed++;
   endtask

   task automatic test_violation();
      int  base = rec_q.size();
      int  k    = 0;
      wr_t e;
      resp_en = 1'b0;
      start_dl(8'd0);
      send_byte(25'd0, 8'h33);
      send_byte(25'd1, 8'h44);
      while (!mem_we && k < 20) begin
         @(negedge clk_sys);
         k++;
      end
      ioctl_addr = 25'd2;
      ioctl_dout = 8'h99;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (mem_din !== 16'h4433 || mem_be !== 2'b11 || ioctl_wait !== 1'b1)
         $display("FAIL viol_hold: got din=%h be=%b wait=%b want 4433/11/1", mem_din, mem_be,
                  ioctl_wait);
      else passed++;
      resp_en = 1'b1;
      end_dl(100);
      e = '{24'd0, 16'h4433, 2'b11};
      checks++;
      if (rec_q.size() != base + 1) $display("FAIL viol_count: got %0d want 1", rec_q.size() - base);
      else if (rec_q[base] !== e) $display("FAIL viol_write: got %h want %h", rec_q[base], e);
      else passed++;
      checks++;
      if (word_count !== 24'd1) $display("FAIL viol_wc: got %0d want 1", word_count);
      else passed++;
   endtask

   task automatic test_random();
      byte_t       b;
      logic [24:0] a;
      int          n, r, base, ldb;
      ack_lat = -1;
      spur_en = 1'b1;
      for (int t = 0; t < 4; t++) begin
         stim_q.delete();
         a = 25'($urandom_range(0, 255));
         n = int'($urandom_range(6, 20));
         for (int i = 0; i < n; i++) begin
            b.addr = a;
            b.data = 8'($urandom);
            stim_q.push_back(b);
            r = int'($urandom_range(0, 9));
            if (r < 6) a = a + 25'd1;
            else if (r < 8) a = 25'($urandom_range(0, 1023));
         end
         build_expected();
         base = rec_q.size();
         ldb  = ld_count;
         start_dl(8'd0);
         checks++;
         if (word_count !== 24'd0) $display("FAIL rand_wc_clear[%0d]: got %0d want 0", t, word_count);
         else passed++;
         foreach (stim_q[i]) begin
            send_byte(stim_q[i].addr, stim_q[i].data);
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
         end
         end_dl(200);
         checks++;
         if (rec_q.size() - base != exp_q.size())
            $display("FAIL rand_count[%0d]: got %0d want %0d", t, rec_q.size() - base, exp_q.size());
         else passed++;
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (base + i >= rec_q.size())
               $display("FAIL rand_write[%0d.%0d]: got none want %h", t, i, exp_q[i]);
            else if (rec_q[base+i] !== exp_q[i])
               $display("FAIL rand_write[%0d.%0d]: got %h want %h", t, i, rec_q[base+i], exp_q[i]);
            else passed++;
         end
         checks++;
         if (word_count !== 24'(exp_q.size()))
            $display("FAIL rand_wc[%0d]: got %0d want %0d", t, word_count, exp_q.size());
         else passed++;
         checks++;
         if (ld_count - ldb != 1)
            $display("FAIL rand_done[%0d]: got %0d pulses want 1", t, ld_count - ldb);
         else passed++;
      end
      spur_en = 1'b0;
   endtask

   task automatic test_monitors();
      checks++;
      if (viol != 0) $display("FAIL we_without_wait: got %0d cycles want 0", viol);
      else passed++;
      checks++;
      if (unstable != 0) $display("FAIL req_stability: got %0d changes want 0", unstable);
      else passed++;
   endtask

   initial begin : main
      for (int i = 0; i < 8; i++) dip_m[i] = 8'hFF;
      test_reset();
      test_pair();
      test_five();
      test_stage();
      test_dip();
      test_reset_mid_write();
      test_violation();
      test_random();
      test_monitors();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ROM_INDEX, default 8'd0, ioctl_index value whose bytes are written to memory.
REQ-002 Parameter DIP_INDEX, default 8'd254, ioctl_index value whose bytes load the DIP-switch bank.
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high; driven without ioctl_download so the loader runs during download.
REQ-005 ioctl_download  in  1  download window active.
REQ-006 ioctl_wr  in  1  one-cycle byte strobe.
REQ-007 ioctl_index  in  8  download target selector.
REQ-008 ioctl_addr  in  25  byte address.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 ioctl_wait  out  1  backpressure to hps_io; no ioctl_wr is accepted while high.
REQ-011 mem_addr  out  24  16-bit word address (ioctl_addr[24:1]).
REQ-012 mem_din  out  16  write data; even byte on [7:0], odd byte on [15:8].
REQ-013 mem_be  out  2  byte enables; [0] = even byte, [1] = odd byte.
REQ-014 mem_we  out  1  write request; held high until acknowledged.
REQ-015 mem_ack  in  1  one-cycle acknowledge from the SDRAM controller.
REQ-016 dsw_flat  out  64  DIP bytes 0..7; byte n on [8n+7:8n].
REQ-017 load_done  out  1  one-cycle pulse when a ROM download completes.
REQ-018 word_count  out  24  number of acknowledged ROM writes in the current download.

Function
REQ-019 The loader SHALL implement a four-state FSM: IDLE, HALF, WRITE, FLUSH.
REQ-020 Only strobes with ioctl_download=1 and ioctl_index=ROM_INDEX SHALL reach memory; all other strobes SHALL be ignored, except DIP strobes (REQ-030).
REQ-021 IDLE, even-address strobe: latch the byte into lo, latch the word address, go to HALF.
REQ-022 IDLE, odd-address strobe: load mem_din[15:8], set be=2'b10, go to WRITE.
REQ-023 HALF, odd strobe to the same word address: set be=2'b11, go to WRITE (next cycle).
REQ-024 HALF, strobe to a different word address: capture the new byte in a one-deep stage register, then issue the held byte with be=2'b01 (go to WRITE).
REQ-025 HALF, ioctl_download falls: go to FLUSH, then issue the held byte with be=2'b01.
REQ-026 WRITE: mem_we=1 with mem_addr, mem_din and mem_be stable until mem_ack; on ack, increment word_count.
REQ-027 WRITE, after ack: if the stage register is valid, process the staged byte as in IDLE; otherwise go to IDLE.
REQ-028 ioctl_wait SHALL be 1 in WRITE and FLUSH, and while the stage register is valid; 0 otherwise.
REQ-029 load_done SHALL pulse exactly one cycle after ioctl_download has fallen for ROM_INDEX and no write is pending or held; word_count SHALL clear on the next rising edge of ioctl_download.
REQ-030 DIP strobe (index=DIP_INDEX and ioctl_addr[24:3]==0): write ioctl_dout to byte ioctl_addr[2:0] in the same cycle, with no memory access and no wait.
REQ-031 A DIP strobe with ioctl_addr[24:3]!=0 SHALL be ignored.
REQ-032 A strobe arriving while ioctl_wait=1 is a protocol violation; it SHALL be dropped and the FSM state SHALL be unaffected.
REQ-033 A mem_ack outside WRITE SHALL be ignored.

Reset
REQ-034 On reset the FSM SHALL enter IDLE, and the outputs SHALL clear to: mem_we=0, ioctl_wait=0, mem_be=0, mem_addr=0, mem_din=0, load_done=0, word_count=0; the stage register and held byte SHALL be invalidated.
REQ-035 Reset during WRITE SHALL abandon the request immediately, even though the controller may still complete it.
REQ-036 The DIP bank SHALL be excluded from reset and SHALL power up at 8'hFF per byte, so that an OSD reset preserves DIP settings.

Structure
REQ-037 The FSM state enum, DIP_BANK_SIZE=8 and default indices SHALL live in the shared core package.
REQ-038 The DIP bank SHALL be a sub-module dip_bank (8x8 register file with byte-addressed write).

Verification
REQ-039 Bytes 0x11@0, 0x22@1, mem_ack 2 cycles after mem_we -> one write: addr=0, din=16'h2211, be=2'b11; wait high until ack; word_count=1.
REQ-040 Bytes @0..4 then download falls -> three writes, the last being addr=2, be=2'b01, din[7:0]=byte4; then a single load_done pulse.
REQ-041 Bytes @6 then @10 -> write addr=3, be=2'b01, followed by the staged byte producing HALF for addr=5; ioctl_wait stays high through both.
REQ-042 Index 254, bytes 0xA5@3 and 0x5A@9 -> dsw_flat[31:24]=0xA5; byte 9 ignored; mem_we never asserted.
REQ-043 Reset asserted while mem_we=1 -> next cycle mem_we=0, ioctl_wait=0, state IDLE; dsw_flat unchanged.
REQ-044 Strobe injected while ioctl_wait=1 -> dropped; the pending write completes with its original data.
